// File: rtl/pwm_deadtime.sv
// pwm_deadtime: converts a single PWM bit into complementary high/low gate
// drives for one half-bridge leg. It inserts a programmable dead interval
// between the two drives and latches a shutdown when an external fault trips.
// All outputs are flops loaded from the next-state decode, so they cannot glitch.
module pwm_deadtime #(
  parameter int DT_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwm_in,
  input  logic            en,
  input  logic [DT_W-1:0] dead_cycles,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            hi_out,
  output logic            lo_out,
  output logic            dead_active,
  output logic            fault_flag
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

  state_t           state_reg, state_next;
  logic [DT_W-1:0]  cnt_reg, cnt_next;
  logic [DT_W-1:0]  cnt_load;
  logic             hi_reg, hi_next;
  logic             lo_reg, lo_next;
  logic             dead_reg, dead_next;
  logic             fault_reg, fault_next;

  // fault_in is asynchronous. Stage 0 samples the pin, and each later stage
  // samples the stage before it.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   fault_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = fault_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign fault_s = sync_reg[SYNC_STAGES-1];

  // Fault synchroniser shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  // A dead_cycles value of 0 behaves like 1. The counter counts down to 0,
  // so it is loaded with N-1 and DEAD lasts exactly max(N,1) cycles.
  assign cnt_load = (dead_cycles == '0) ? '0 : (dead_cycles - CNT_ONE);

  // State, dead counter and registered output decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      hi_reg    <= 1'b0;
      lo_reg    <= 1'b0;
      dead_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      dead_reg  <= dead_next;
      fault_reg <= fault_next;
    end
  end

  // Next-state logic. The priority order is: fault, then enable, then the
  // normal PWM transitions. FAULT ignores en, so only fault_clr releases it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    if (fault_s) begin
      state_next = ST_FAULT;
    end else if (state_reg == ST_FAULT) begin
      if (fault_clr) begin
        state_next = ST_IDLE;
      end
    end else if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_DEAD;
          cnt_next   = cnt_load;
        end
        ST_HI: begin
          if (!pwm_in) begin
            state_next = ST_DEAD;
            cnt_next   = cnt_load;
          end
        end
        ST_LO: begin
          if (pwm_in) begin
            state_next = ST_DEAD;
            cnt_next   = cnt_load;
          end
        end
        ST_DEAD: begin
          // pwm_in is sampled again when the interval expires. A pulse
          // shorter than the dead time therefore returns to the original side.
          if (cnt_reg == '0) begin
            state_next = pwm_in ? ST_HI : ST_LO;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state, so the outputs change on the same edge as the state
  always_comb begin
    hi_next    = (state_next == ST_HI);
    lo_next    = (state_next == ST_LO);
    dead_next  = (state_next == ST_DEAD);
    fault_next = (state_next == ST_FAULT);
  end

  assign hi_out      = hi_reg;
  assign lo_out      = lo_reg;
  assign dead_active = dead_reg;
  assign fault_flag  = fault_reg;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed testbench for pwm_deadtime. The expected values are worked out by
// hand from the edge numbering, and every comparison goes through chk().
module tb_pwm_deadtime;

  localparam int DT_W = 8;
  localparam int SYNC_STAGES = 2;

  logic            clk;
  logic            rst_n;
  logic            pwm_in;
  logic            en;
  logic [DT_W-1:0] dead_cycles;
  logic            fault_in;
  logic            fault_clr;
  logic            hi_out;
  logic            lo_out;
  logic            dead_active;
  logic            fault_flag;

  int n_vec;
  int n_err;

  pwm_deadtime #(.DT_W(DT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .en          (en),
    .dead_cycles (dead_cycles),
    .fault_in    (fault_in),
    .fault_clr   (fault_clr),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .dead_active (dead_active),
    .fault_flag  (fault_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The outputs packed as {fault, dead, lo, hi}
  function automatic logic [3:0] outs();
    return {fault_flag, dead_active, lo_out, hi_out};
  endfunction

  // Tick n times, expecting DEAD with both drives off on every one
  task automatic dead_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {28'd0, outs()}, 32'h4);
    end
  endtask

  // Sine-modulated duty per 16-cycle PWM period; every run length is at least 2
  logic [3:0] duty_tab [16];
  initial begin
    duty_tab = '{4'd8, 4'd10, 4'd12, 4'd14, 4'd14, 4'd14, 4'd12, 4'd10,
                 4'd8, 4'd6,  4'd4,  4'd2,  4'd2,  4'd2,  4'd4,  4'd6};
  end

  initial begin
    logic p, p_prev;
    logic [3:0] exp_o;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    en = 1'b0;
    pwm_in = 1'b0;
    dead_cycles = 8'd8;
    fault_in = 1'b0;
    fault_clr = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_outs", {28'd0, outs()}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_en0", {28'd0, outs()}, 32'h0);

    // Bring-up: from IDLE into DEAD(8), then into HI
    en = 1'b1;
    pwm_in = 1'b1;
    tick();
    chk("startup_dead", {28'd0, outs()}, 32'h4);
    dead_run("startup_dead_run", 7);
    tick();
    chk("startup_hi", {28'd0, outs()}, 32'h1);

    // Test 1: async reset while in HI clears hi_out before the next edge
    rst_n = 1'b0;
    #2;
    chk("async_rst_hi", {31'd0, hi_out}, 32'h0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_release", {28'd0, outs()}, 32'h0);
    tick();
    chk("post_rst_idle", {28'd0, outs()}, 32'h0);

    // Bring-up into HI again
    en = 1'b1;
    tick();
    dead_run("reup_dead_run", 7);
    tick();
    chk("reup_hi", {28'd0, outs()}, 32'h1);

    // Test 2: pwm 1->0 with dead_cycles=8
    pwm_in = 1'b0;
    tick();
    chk("hi_drop_at_k", {28'd0, outs()}, 32'h4);
    dead_run("hl_dead_run", 7);
    tick();
    chk("lo_at_k8", {28'd0, outs()}, 32'h2);

    // Test 4: 3-cycle glitch in LO is absorbed and returns to LO
    pwm_in = 1'b1;
    tick();
    chk("glitch_dead", {28'd0, outs()}, 32'h4);
    tick();
    chk("glitch_dead1", {28'd0, outs()}, 32'h4);
    tick();
    chk("glitch_dead2", {28'd0, outs()}, 32'h4);
    pwm_in = 1'b0;
    dead_run("glitch_dead_run", 5);
    tick();
    chk("glitch_back_lo", {28'd0, outs()}, 32'h2);

    // Test 3: dead_cycles=0 (acts as 1) across one 256-cycle sine period
    dead_cycles = 8'd0;
    p_prev = 1'b0;
    for (int i = 0; i < 256; i++) begin
      p = ((i % 16) < int'(duty_tab[i / 16]));
      pwm_in = p;
      tick();
      if (p != p_prev) exp_o = 4'h4;
      else if (p) exp_o = 4'h1;
      else exp_o = 4'h2;
      chk("sine_outs", {28'd0, outs()}, {28'd0, exp_o});
      chk("sine_no_overlap", {31'd0, hi_out & lo_out}, 32'h0);
      p_prev = p;
    end

    // Enter HI with an 8-cycle dead time
    dead_cycles = 8'd8;
    pwm_in = 1'b1;
    tick();
    dead_run("tohi_dead_run", 7);
    tick();
    chk("tohi_hi", {28'd0, outs()}, 32'h1);

    // fault_clr with no fault latched has no effect
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_no_fault", {28'd0, outs()}, 32'h1);

    // Test 5: a 1-cycle fault pulse reaches FAULT SYNC_STAGES edges after it is sampled
    fault_in = 1'b1;
    tick();
    fault_in = 1'b0;
    chk("fault_sync0", {28'd0, outs()}, 32'h1);
    tick();
    chk("fault_sync1", {28'd0, outs()}, 32'h1);
    tick();
    chk("fault_latched", {28'd0, outs()}, 32'h8);
    fault_in = 1'b1;
    tick();
    tick();
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_ignored", {28'd0, outs()}, 32'h8);
    fault_in = 1'b0;
    tick();
    tick();
    tick();
    chk("fault_held", {28'd0, outs()}, 32'h8);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("fault_cleared_idle", {28'd0, outs()}, 32'h0);
    tick();
    chk("after_clr_dead", {28'd0, outs()}, 32'h4);
    dead_run("after_clr_dead_run", 7);
    tick();
    chk("after_clr_hi", {28'd0, outs()}, 32'h1);

    // Test 6: en=0 mid-DEAD (cnt=5), then a full 8-cycle DEAD on re-enable
    pwm_in = 1'b0;
    tick();
    chk("en_dead_k", {28'd0, outs()}, 32'h4);
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("en_off_idle", {28'd0, outs()}, 32'h0);
    en = 1'b1;
    tick();
    chk("reen_dead", {28'd0, outs()}, 32'h4);
    dead_cycles = 8'd3;
    dead_run("reen_dead_run", 7);
    tick();
    chk("reen_lo", {28'd0, outs()}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
